// File: rtl/rvl_reg_scan_reader_if.sv
// Reveal Controller user register interface as seen by a read-side initiator.
// The master raises usr_ce for one cycle with usr_addr; usr_rdata is valid RD_LATENCY cycles later.
interface rvl_reg_scan_reader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  usr_ce;
   logic                  usr_we;
   logic [ADDR_WIDTH-1:0] usr_addr;
   logic [DATA_WIDTH-1:0] usr_rdata;

   modport master (
      output usr_ce,
      output usr_we,
      output usr_addr,
      input  usr_rdata
   );

   modport slave (
      input  usr_ce,
      input  usr_we,
      input  usr_addr,
      output usr_rdata
   );
endinterface

// File: rtl/rvl_reg_scan_reader.sv
// Sweeps a register window with single-cycle read strobes, captures each word after a fixed
// latency, presents it on rd_valid/rd_addr/rd_data and latches one register's upper byte for display.
module rvl_reg_scan_reader #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 16,
   parameter int BASE_ADDR  = 0,
   parameter int RD_LATENCY = 1,
   parameter int GAP_CYCLES = 1000
) (
   input  logic                  sys_clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  continuous,
   input  logic [ADDR_WIDTH-1:0] disp_sel,
   rvl_reg_scan_reader_if.master usr_bus,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  sweep_done,
   output logic [7:0]            seven_seg,
   output logic [2:0]            dbg_state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;

   localparam int LAT_W = $clog2(RD_LATENCY + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RD_LATENCY);
   localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_CYCLES);

   logic [2:0]            state_q,    state_d;
   logic [ADDR_WIDTH-1:0] index_q,    index_d;
   logic [LAT_W-1:0]      lat_cnt_q,  lat_cnt_d;
   logic [GAP_W-1:0]      gap_cnt_q,  gap_cnt_d;
   logic                  ce_q,       ce_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic                  valid_q,    valid_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
   logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
   logic                  busy_q,     busy_d;
   logic                  done_q,     done_d;
   logic [7:0]            seg_q,      seg_d;

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      lat_cnt_d = lat_cnt_q;
      gap_cnt_d = gap_cnt_q;
      addr_d    = addr_q;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      seg_d     = seg_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start || continuous) begin
               state_d = S_ISSUE;
               index_d = '0;
            end
         end
         S_ISSUE: begin
            state_d   = S_WAIT;
            lat_cnt_d = LAT_W'(1);
         end
         S_WAIT: begin
            // The captured word and sweep_done land together so they appear with rd_valid.
            if (lat_cnt_q == LAT_LAST) begin
               state_d   = S_CAPTURE;
               rd_data_d = usr_bus.usr_rdata;
               rd_addr_d = addr_q;
               done_d    = (index_q == LAST_IDX);
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         S_CAPTURE: begin
            if (index_q == disp_sel) begin
               seg_d = rd_data_q[DATA_WIDTH-1 -: 8];
            end
            if (index_q != LAST_IDX) begin
               index_d = index_q + ADDR_WIDTH'(1);
               state_d = S_ISSUE;
            end else begin
               index_d = '0;
               if (continuous) begin
                  state_d   = S_GAP;
                  gap_cnt_d = GAP_W'(1);
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (!continuous) begin
               state_d   = S_IDLE;
               gap_cnt_d = '0;
            end else if (gap_cnt_q == GAP_LAST) begin
               state_d   = S_ISSUE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs decode the next state so every one of them is a flop aligned with state_q.
      if (state_d == S_ISSUE) begin
         addr_d = BASE + index_d;
      end
      ce_d    = (state_d == S_ISSUE);
      valid_d = (state_d == S_CAPTURE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         lat_cnt_q <= '0;
         gap_cnt_q <= '0;
         ce_q      <= 1'b0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         seg_q     <= 8'h5A;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         lat_cnt_q <= lat_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         ce_q      <= ce_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         seg_q     <= seg_d;
      end
   end

   assign usr_bus.usr_ce   = ce_q;
   assign usr_bus.usr_we   = 1'b0;
   assign usr_bus.usr_addr = addr_q;
   assign rd_valid         = valid_q;
   assign rd_addr          = rd_addr_q;
   assign rd_data          = rd_data_q;
   assign busy             = busy_q;
   assign sweep_done       = done_q;
   assign seven_seg        = seg_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_rvl_reg_scan_reader.sv
// Bench for rvl_reg_scan_reader: a latency-1 instance (A) and a latency-3 instance (B)
// with register responders and a queue of expected captures.
module tb_rvl_reg_scan_reader;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int NREGS = 4;
   localparam int BASE  = 16'h0010;
   localparam int GAP   = 5;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_GAP     = 3'd4;

   logic          sys_clk = 1'b0;
   logic          rstn    = 1'b0;
   logic          start_a = 1'b0;
   logic          cont_a  = 1'b0;
   logic          start_b = 1'b0;
   logic          cont_b  = 1'b0;
   logic [AW-1:0] disp_sel = '0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] resp_mem [NREGS];

   always #5 sys_clk = ~sys_clk;

   rvl_reg_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
   rvl_reg_scan_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

   logic          a_valid, a_busy, a_done, b_valid, b_busy, b_done;
   logic [AW-1:0] a_raddr, b_raddr;
   logic [DW-1:0] a_rdata, b_rdata;
   logic [7:0]    a_seg, b_seg;
   logic [2:0]    a_state, b_state;

   rvl_reg_scan_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREGS), .BASE_ADDR(BASE),
      .RD_LATENCY(1), .GAP_CYCLES(GAP)
   ) dut_a (
      .sys_clk(sys_clk), .rstn(rstn), .start(start_a), .continuous(cont_a),
      .disp_sel(disp_sel), .usr_bus(bus_a.master), .rd_valid(a_valid), .rd_addr(a_raddr),
      .rd_data(a_rdata), .busy(a_busy), .sweep_done(a_done), .seven_seg(a_seg),
      .dbg_state(a_state)
   );

   rvl_reg_scan_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREGS), .BASE_ADDR(BASE),
      .RD_LATENCY(3), .GAP_CYCLES(GAP)
   ) dut_b (
      .sys_clk(sys_clk), .rstn(rstn), .start(start_b), .continuous(cont_b),
      .disp_sel(disp_sel), .usr_bus(bus_b.master), .rd_valid(b_valid), .rd_addr(b_raddr),
      .rd_data(b_rdata), .busy(b_busy), .sweep_done(b_done), .seven_seg(b_seg),
      .dbg_state(b_state)
   );

   // Responder A: one-cycle registered read from a small register file.
   always @(posedge sys_clk) begin
      if (bus_a.usr_ce) bus_a.usr_rdata <= resp_mem[bus_a.usr_addr[1:0]];
   end

   // Responder B: data only in the third cycle after the strobe, X otherwise.
   logic          ce_p1 = 1'b0, ce_p2 = 1'b0;
   logic [AW-1:0] addr_p1 = '0, addr_p2 = '0;
   always @(posedge sys_clk) begin
      ce_p1 <= bus_b.usr_ce;  addr_p1 <= bus_b.usr_addr;
      ce_p2 <= ce_p1;         addr_p2 <= addr_p1;
      bus_b.usr_rdata <= ce_p2 ? (addr_p2 ^ 16'hA000) : 'x;
   end

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge sys_clk);
      n_tests++; if (a_seg !== 8'h5A) begin n_fail++; $display("FAIL reset_seg: got %h expected 5a", a_seg); end
      n_tests++; if ({bus_a.usr_ce, a_valid, a_busy, a_done} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {bus_a.usr_ce, a_valid, a_busy, a_done}); end
      n_tests++; if (bus_a.usr_addr !== '0 || a_rdata !== '0 || a_raddr !== '0) begin n_fail++; $display("FAIL reset_bus: addr %h rdata %h raddr %h expected 0", bus_a.usr_addr, a_rdata, a_raddr); end
      n_tests++; if (bus_a.usr_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus_a.usr_we); end
      rstn = 1'b1;
      repeat (4) @(negedge sys_clk);
      n_tests++; if (a_state !== S_IDLE || a_busy !== 1'b0 || bus_a.usr_ce !== 1'b0) begin n_fail++; $display("FAIL reset_idle: state %0d busy %b ce %b expected 0 0 0", a_state, a_busy, bus_a.usr_ce); end
      n_tests++; if (a_seg !== 8'h5A) begin n_fail++; $display("FAIL reset_seg_hold: got %h expected 5a", a_seg); end
   endtask

   task automatic test_single_sweep();
      int n_ce = 0, n_val = 0, last_ce = -1;
      bit fin = 1'b0;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      disp_sel = 16'd16;
      for (int i = 0; i < NREGS; i++) begin exp_q.push_back(resp_mem[i]); exp_addr_q.push_back(AW'(BASE + i)); end
      start_a = 1'b1;
      for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
         @(negedge sys_clk);
         start_a = 1'b0;
         n_tests++; if (a_seg !== 8'h5A || bus_a.usr_we !== 1'b0) begin n_fail++; $display("FAIL single_seg_we: seg %h we %b expected 5a 0", a_seg, bus_a.usr_we); end
         if (bus_a.usr_ce) begin
            n_tests++; if (bus_a.usr_addr !== AW'(BASE + n_ce)) begin n_fail++; $display("FAIL single_addr: got %h expected %h", bus_a.usr_addr, AW'(BASE + n_ce)); end
            if (n_ce == 0) begin n_tests++; if (cyc != 0) begin n_fail++; $display("FAIL single_first_ce: got cycle %0d expected 0", cyc); end end
            else begin n_tests++; if (cyc - last_ce != 3) begin n_fail++; $display("FAIL single_period: got %0d expected 3", cyc - last_ce); end end
            last_ce = cyc; n_ce++;
         end
         if (a_valid) begin
            n_val++;
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL single_extra_valid: got data %h expected none", a_rdata); end
            else begin
               ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
               n_tests++; if (a_rdata !== ed || a_raddr !== ea) begin n_fail++; $display("FAIL single_data: got %h@%h expected %h@%h", a_rdata, a_raddr, ed, ea); end
            end
            n_tests++; if (a_done !== (n_val == NREGS)) begin n_fail++; $display("FAIL single_done: got %b at read %0d", a_done, n_val); end
            if (n_val == NREGS) fin = 1'b1;
         end else if (a_done) begin n_tests++; n_fail++; $display("FAIL single_stray_done: got 1 expected 0"); end
      end
      if (!fin) begin n_tests++; n_fail++; $display("FAIL single_timeout: got %0d reads expected %0d", n_val, NREGS); end
      @(negedge sys_clk);
      n_tests++; if (a_state !== S_IDLE || a_busy !== 1'b0 || n_ce != NREGS) begin n_fail++; $display("FAIL single_end: state %0d busy %b strobes %0d expected 0 0 4", a_state, a_busy, n_ce); end
   endtask

   task automatic test_latency();
      int n_ce = 0, n_val = 0, last_ce = -1;
      bit fin = 1'b0;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      for (int i = 0; i < NREGS; i++) begin exp_q.push_back(DW'(BASE + i) ^ 16'hA000); exp_addr_q.push_back(AW'(BASE + i)); end
      start_b = 1'b1;
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         @(negedge sys_clk);
         start_b = 1'b0;
         if (bus_b.usr_ce) begin
            if (n_ce > 0) begin n_tests++; if (cyc - last_ce != 5) begin n_fail++; $display("FAIL lat_period: got %0d expected 5", cyc - last_ce); end end
            last_ce = cyc; n_ce++;
         end
         if (b_valid) begin
            n_val++;
            n_tests++; if (cyc - last_ce != 4) begin n_fail++; $display("FAIL lat_issue_to_valid: got %0d expected 4", cyc - last_ce); end
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL lat_extra_valid: got data %h expected none", b_rdata); end
            else begin
               ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
               n_tests++; if (b_rdata !== ed || b_raddr !== ea) begin n_fail++; $display("FAIL lat_data: got %h@%h expected %h@%h", b_rdata, b_raddr, ed, ea); end
            end
            n_tests++; if (b_done !== (n_val == NREGS)) begin n_fail++; $display("FAIL lat_done: got %b at read %0d", b_done, n_val); end
            if (n_val == NREGS) fin = 1'b1;
         end
      end
      if (!fin) begin n_tests++; n_fail++; $display("FAIL lat_timeout: got %0d reads expected %0d", n_val, NREGS); end
      @(negedge sys_clk);
      n_tests++; if (b_state !== S_IDLE) begin n_fail++; $display("FAIL lat_end: state %0d expected 0", b_state); end
   endtask

   task automatic test_display();
      int n_val = 0, tail = 0;
      logic [7:0] exp_seg = 8'h5A;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      resp_mem[2] = 16'hC3F0;
      disp_sel = 16'd2;
      for (int i = 0; i < NREGS; i++) begin exp_q.push_back(resp_mem[i]); exp_addr_q.push_back(AW'(BASE + i)); end
      start_a = 1'b1;
      for (int cyc = 0; cyc < 60 && tail < 4; cyc++) begin
         @(negedge sys_clk);
         start_a = 1'b0;
         n_tests++; if (a_seg !== exp_seg) begin n_fail++; $display("FAIL disp_seg: got %h expected %h at cycle %0d", a_seg, exp_seg, cyc); end
         if (n_val == NREGS) tail++;
         if (a_valid && exp_q.size() > 0) begin
            n_val++;
            ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
            n_tests++; if (a_rdata !== ed || a_raddr !== ea) begin n_fail++; $display("FAIL disp_data: got %h@%h expected %h@%h", a_rdata, a_raddr, ed, ea); end
            if (n_val == 3) exp_seg = ed[15:8];
         end
      end
      n_tests++; if (n_val != NREGS) begin n_fail++; $display("FAIL disp_timeout: got %0d reads expected %0d", n_val, NREGS); end
      resp_mem[2] = DW'(BASE + 2) ^ 16'hA000;
   endtask

   task automatic test_continuous();
      int n_ce = 0, n_val = 0, done_cyc = -1;
      bit fin = 1'b0;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      disp_sel = 16'd16;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < NREGS; i++) begin exp_q.push_back(resp_mem[i]); exp_addr_q.push_back(AW'(BASE + i)); end
      cont_a = 1'b1;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         @(negedge sys_clk);
         start_a = 1'b0;
         if (n_val == NREGS && cyc > done_cyc && cyc <= done_cyc + GAP) begin
            n_tests++; if (a_state !== S_GAP || a_busy !== 1'b1 || bus_a.usr_ce !== 1'b0) begin n_fail++; $display("FAIL cont_gap: state %0d busy %b ce %b expected 4 1 0", a_state, a_busy, bus_a.usr_ce); end
         end
         if (bus_a.usr_ce) begin
            n_tests++; if (bus_a.usr_addr !== AW'(BASE + (n_ce % NREGS))) begin n_fail++; $display("FAIL cont_addr: got %h expected %h", bus_a.usr_addr, AW'(BASE + (n_ce % NREGS))); end
            if (n_ce == NREGS) begin
               n_tests++; if (cyc - done_cyc != GAP + 1) begin n_fail++; $display("FAIL cont_gap_len: got %0d expected %0d", cyc - done_cyc - 1, GAP); end
               start_a = 1'b1;
            end
            if (n_ce == NREGS + 1) cont_a = 1'b0;
            n_ce++;
         end
         if (a_valid) begin
            n_val++;
            if (exp_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL cont_extra_valid: got data %h expected none", a_rdata); end
            else begin
               ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
               n_tests++; if (a_rdata !== ed || a_raddr !== ea) begin n_fail++; $display("FAIL cont_data: got %h@%h expected %h@%h", a_rdata, a_raddr, ed, ea); end
            end
            n_tests++; if (a_done !== (n_val % NREGS == 0)) begin n_fail++; $display("FAIL cont_done: got %b at read %0d", a_done, n_val); end
            if (n_val == NREGS) done_cyc = cyc;
            if (n_val == 2 * NREGS) fin = 1'b1;
         end
      end
      if (!fin) begin n_tests++; n_fail++; $display("FAIL cont_timeout: got %0d reads expected %0d", n_val, 2 * NREGS); end
      for (int k = 0; k < 20; k++) begin
         @(negedge sys_clk);
         n_tests++; if (bus_a.usr_ce !== 1'b0 || a_busy !== 1'b0 || a_valid !== 1'b0) begin n_fail++; $display("FAIL cont_stop: ce %b busy %b valid %b expected 0 0 0", bus_a.usr_ce, a_busy, a_valid); end
      end
      n_tests++; if (n_ce != 2 * NREGS) begin n_fail++; $display("FAIL cont_strobes: got %0d expected %0d", n_ce, 2 * NREGS); end
   endtask

   task automatic test_gap_drop();
      int n_val = 0, done_cyc = -1;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      for (int i = 0; i < NREGS; i++) begin exp_q.push_back(resp_mem[i]); exp_addr_q.push_back(AW'(BASE + i)); end
      cont_a = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge sys_clk);
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            n_tests++; if (a_state !== S_GAP) begin n_fail++; $display("FAIL drop_in_gap: state %0d expected 4", a_state); end
            cont_a = 1'b0;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 2) begin
            n_tests++; if (a_state !== S_IDLE || a_busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: state %0d busy %b expected 0 0", a_state, a_busy); end
         end
         if (done_cyc >= 0 && cyc > done_cyc + 1) begin
            n_tests++; if (bus_a.usr_ce !== 1'b0) begin n_fail++; $display("FAIL drop_no_ce: got 1 expected 0"); end
         end
         if (a_valid && exp_q.size() > 0) begin
            n_val++;
            ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
            n_tests++; if (a_rdata !== ed || a_raddr !== ea) begin n_fail++; $display("FAIL drop_data: got %h@%h expected %h@%h", a_rdata, a_raddr, ed, ea); end
            if (n_val == NREGS) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 12) break;
      end
      n_tests++; if (done_cyc < 0) begin n_fail++; $display("FAIL drop_timeout: got %0d reads expected %0d", n_val, NREGS); cont_a = 1'b0; end
   endtask

   task automatic test_reset_mid();
      int n_ce = 0, n_val = 0, ce2_cyc = -1;
      bit hit = 1'b0;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      exp_q.push_back(resp_mem[0]); exp_addr_q.push_back(AW'(BASE));
      start_a = 1'b1;
      for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
         @(negedge sys_clk);
         start_a = 1'b0;
         if (ce2_cyc >= 0 && cyc == ce2_cyc + 1) begin
            n_tests++; if (a_state !== S_WAIT) begin n_fail++; $display("FAIL mid_in_wait: state %0d expected 2", a_state); end
            rstn = 1'b0;
            #1;
            n_tests++; if ({bus_a.usr_ce, a_valid, a_busy, a_done} !== 4'b0 || a_state !== S_IDLE || a_seg !== 8'h5A) begin n_fail++; $display("FAIL mid_reset: ce/valid/busy/done %b state %0d seg %h expected 0000 0 5a", {bus_a.usr_ce, a_valid, a_busy, a_done}, a_state, a_seg); end
            hit = 1'b1;
         end
         if (bus_a.usr_ce) begin n_ce++; if (n_ce == 2) ce2_cyc = cyc; end
         if (!hit && a_valid && exp_q.size() > 0) begin
            ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
            n_tests++; if (a_rdata !== ed || a_raddr !== ea) begin n_fail++; $display("FAIL mid_first: got %h@%h expected %h@%h", a_rdata, a_raddr, ed, ea); end
         end
      end
      n_tests++; if (!hit || exp_q.size() != 0) begin n_fail++; $display("FAIL mid_timeout: reset hit %b pending %0d expected 1 0", hit, exp_q.size()); end
      exp_q.delete(); exp_addr_q.delete();
      rstn = 1'b0;
      repeat (3) begin
         @(negedge sys_clk);
         n_tests++; if (a_valid !== 1'b0 || bus_a.usr_ce !== 1'b0) begin n_fail++; $display("FAIL mid_hold: valid %b ce %b expected 0 0", a_valid, bus_a.usr_ce); end
      end
      rstn = 1'b1;
      @(negedge sys_clk);
      for (int i = 0; i < NREGS; i++) begin exp_q.push_back(resp_mem[i]); exp_addr_q.push_back(AW'(BASE + i)); end
      start_a = 1'b1;
      n_ce = 0;
      for (int cyc = 0; cyc < 60 && n_val < NREGS; cyc++) begin
         @(negedge sys_clk);
         start_a = 1'b0;
         if (bus_a.usr_ce && n_ce == 0) begin
            n_tests++; if (bus_a.usr_addr !== AW'(BASE)) begin n_fail++; $display("FAIL mid_restart_addr: got %h expected %h", bus_a.usr_addr, AW'(BASE)); end
         end
         if (bus_a.usr_ce) n_ce++;
         if (a_valid && exp_q.size() > 0) begin
            n_val++;
            ed = exp_q.pop_front(); ea = exp_addr_q.pop_front();
            n_tests++; if (a_rdata !== ed || a_raddr !== ea) begin n_fail++; $display("FAIL mid_restart_data: got %h@%h expected %h@%h", a_rdata, a_raddr, ed, ea); end
         end
      end
      n_tests++; if (n_val != NREGS) begin n_fail++; $display("FAIL mid_restart_timeout: got %0d reads expected %0d", n_val, NREGS); end
      @(negedge sys_clk);
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) resp_mem[i] = DW'(BASE + i) ^ 16'hA000;
      test_reset();
      test_single_sweep();
      test_latency();
      test_display();
      test_continuous();
      test_gap_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish by 500000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rvl_reg_scan_reader.md
Name: rvl_reg_scan_reader

Overview:
Read-side initiator for the Reveal Controller user register interface. It sweeps a window of register addresses with single-cycle read strobes and waits a fixed read latency before capturing each word. Each captured word is presented on a valid-qualified output. The upper byte of a selected register is latched for the seven-segment display. It sits beside the existing write-side logic on sys_clk and shares the register interface with it; when this block is idle, usr_ce is low.

Parameters:
ADDR_WIDTH, 16, register interface address width
DATA_WIDTH, 16, register interface data width (must be >= 8)
NUM_REGS, 16, registers per sweep (1..2^ADDR_WIDTH)
BASE_ADDR, 0, first address of the sweep
RD_LATENCY, 1, cycles from the usr_ce sample edge to valid usr_rdata (>= 1)
GAP_CYCLES, 1000, idle cycles between sweeps in continuous mode (>= 1)

Ports:
sys_clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  pulse; begins a sweep when idle
continuous  in  1  level; while high, sweeps repeat after GAP_CYCLES
disp_sel  in  ADDR_WIDTH  sweep index (0..NUM_REGS-1) whose data drives seven_seg
usr_ce  out  1  register interface strobe
usr_we  out  1  write enable; held 0
usr_addr  out  ADDR_WIDTH  register address
usr_rdata  in  DATA_WIDTH  register read data
rd_valid  out  1  one-cycle pulse; rd_data/rd_addr valid
rd_addr  out  ADDR_WIDTH  address of the captured word
rd_data  out  DATA_WIDTH  captured word
busy  out  1  high from the first ISSUE through the end of GAP
sweep_done  out  1  one-cycle pulse after the last capture of a sweep
seven_seg  out  8  display byte

Behaviour:
- Reset (async, rstn=0): every output goes to 0, except seven_seg = 8'h5A. FSM = IDLE, index = 0, latency and gap counters = 0. Reset mid-sweep abandons the sweep; there is no resume.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, GAP.
- IDLE: on start=1, or continuous=1 with start=0, go to ISSUE with index=0. Otherwise stay.
- ISSUE (cycle N): usr_ce=1, usr_addr = BASE_ADDR + index (truncated to ADDR_WIDTH). Exactly one cycle. Go to WAIT; latency counter = 1.
- WAIT: usr_ce=0. usr_addr holds its value. When the latency counter equals RD_LATENCY, register usr_rdata at the end of that cycle (cycle N+RD_LATENCY) and go to CAPTURE. Otherwise increment the counter.
- CAPTURE (cycle N+RD_LATENCY+1): rd_valid=1, rd_addr = the issued address, rd_data = the sampled word.
  - If index < NUM_REGS-1: increment index and go to ISSUE. Per-register period = RD_LATENCY+2 cycles.
  - Else: sweep_done=1 in the same cycle, index=0. Go to GAP if continuous=1, else IDLE.
- GAP: count GAP_CYCLES cycles, then go to ISSUE. If continuous drops to 0 during GAP, go to IDLE next cycle.
- start is ignored outside IDLE; no queuing. Dropping continuous mid-sweep lets the current sweep finish.
- busy = 1 in ISSUE, WAIT, CAPTURE and GAP.
- Display update: in CAPTURE with index == disp_sel, seven_seg <= sampled word [DATA_WIDTH-1 : DATA_WIDTH-8], visible the following cycle. If disp_sel >= NUM_REGS, seven_seg never updates.
- Output registration: all outputs are registered. usr_we is constant 0.

Test Plan:
- Reset: hold rstn=0, then release -> seven_seg=8'h5A; usr_ce, rd_valid, busy, sweep_done all 0; FSM stays IDLE with no start.
- Single sweep (RD_LATENCY=1, NUM_REGS=4, BASE_ADDR=16'h0010): responder model returns addr^16'hA000. One start pulse ->
  - usr_ce pulses at addresses 0x10..0x13, 3 cycles apart;
  - rd_valid pulses 4 times with rd_data 0xA010..0xA013;
  - sweep_done pulses coincident with the 4th rd_valid, then IDLE.
- Latency (RD_LATENCY=3): responder drives data only in the cycle 3 cycles after the strobe, X otherwise -> captured values are exact; ISSUE-to-rd_valid = 4 cycles; strobe period = 5 cycles.
- Display: disp_sel=2, register 2 = 16'hC3F0 -> seven_seg = 8'hC3 one cycle after the 3rd rd_valid and holds through later captures. With disp_sel=16, seven_seg stays 8'h5A.
- Continuous (GAP_CYCLES=5): continuous=1 -> consecutive sweeps separated by exactly 5 GAP cycles. Drop continuous mid-sweep -> that sweep completes, then IDLE. start pulses while busy have no effect.
- Reset mid-operation: assert rstn in WAIT of the 2nd read -> usr_ce=0, no rd_valid. After release, a new start begins at BASE_ADDR.
